spi_txn_fsm: RTL and testbench
==============================

SPI_TXN_FSM -- requirements
Module: spi_txn_fsm

Interface
REQ-001 Parameter ADDR_BITS, default 7: address field width, MSB first.
REQ-002 Parameter DATA_BITS, default 8: data field width; shift_q width.
REQ-003 clk  in  1  FPGA clock; all state changes on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cs_n  in  1  conditioned chip select, active-low.
REQ-006 sclk_rise  in  1  one-cycle pulse per SCLK rising edge (same pulse drives shift register peripheralClkEdge).
REQ-007 shift_q  in  DATA_BITS  shift register parallel contents.
REQ-008 addr_we  out  1  one-cycle strobe: latch shift_q[DATA_BITS-1:1] into address latch.
REQ-009 sr_load  out  1  one-cycle strobe to shift register parallelLoad.
REQ-010 dm_we  out  1  one-cycle data memory write enable.
REQ-011 miso_en  out  1  MISO tri-state buffer enable.
REQ-012 busy  out  1  high whenever state is not IDLE.

Function
REQ-013 States SHALL be IDLE, GET_ADDR, LATCH_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, DONE.
REQ-014 IDLE -> GET_ADDR on cycle with cs_n=0; bit counter cleared to 0.
REQ-015 GET_ADDR: counter increments on each sclk_rise; the 8th (ADDR_BITS+1) sclk_rise moves to LATCH_ADDR on the next edge.
REQ-016 LATCH_ADDR (one cycle): addr_we=1; rw=shift_q[0]; rw=1 -> READ_LOAD, rw=0 -> WRITE_SHIFT; counter cleared.
REQ-017 READ_LOAD (one cycle): sr_load=1, then READ_SHIFT.
REQ-018 READ_SHIFT: miso_en=1; counts DATA_BITS sclk_rise pulses, then DONE.
REQ-019 WRITE_SHIFT: counts DATA_BITS sclk_rise pulses, then WRITE_COMMIT.
REQ-020 WRITE_COMMIT (one cycle): dm_we=1, then DONE.
REQ-021 DONE: all strobes 0; cs_n=1 -> IDLE; further sclk_rise ignored.
REQ-022 Strobes (addr_we, sr_load, dm_we) SHALL be Moore outputs, exactly one cycle wide per transaction.
REQ-023 cs_n=1 in any non-IDLE state SHALL force IDLE next edge (abort); abort wins over a simultaneous sclk_rise or final count; no dm_we on aborted write.
REQ-024 sclk_rise during LATCH_ADDR, READ_LOAD or WRITE_COMMIT SHALL be ignored (not counted).
REQ-025 Counter width SHALL be clog2(max(ADDR_BITS+1, DATA_BITS)+1); no wrap within a phase.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, counter 0, addr_we=sr_load=dm_we=miso_en=busy=0, regardless of clk.
REQ-027 Reset mid-transaction SHALL discard it; first transaction after release begins only on cs_n=0 sampled after rst_n=1.

Configuration
REQ-028 Macro SPI_TXN_FSM_ERR_EN defined: adds output err (1 bit), set sticky on any abort (REQ-023) or ignored edge (REQ-024), cleared on IDLE->GET_ADDR and by reset.
REQ-029 Macro undefined: no err port, no error logic; all other behaviour identical.

Structure
REQ-030 Package spi_pkg SHALL hold state enum type, default ADDR_BITS/DATA_BITS constants and RW_READ=1 encoding.
REQ-031 Sub-module spi_bit_counter (clear, increment, terminal-count compare) SHALL be instantiated once.

Verification
REQ-032 Reset: rst_n=0 asynchronously mid-READ_SHIFT -> all outputs 0 before next posedge, state IDLE.
REQ-033 Write: cs_n=0, 8 rises with shift_q=8'hA4 (addr 0x52, rw=0), 8 rises -> addr_we once, dm_we once in cycle after 8th data rise, miso_en never 1.
REQ-034 Read: shift_q=8'hA5 after address phase -> addr_we, then sr_load next cycle, miso_en=1 for exactly 8 rises, dm_we never 1.
REQ-035 Abort: cs_n=1 after 5th data rise of write -> IDLE next cycle, dm_we never asserted, err=1 when SPI_TXN_FSM_ERR_EN.
REQ-036 Simultaneous: cs_n=1 on same cycle as 8th data rise of write -> no dm_we; IDLE next cycle.
REQ-037 Back-to-back: cs_n high one cycle between two writes -> two dm_we strobes, busy low exactly one cycle between.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI transaction sequencer
package spi_pkg;

    localparam int ADDR_BITS_DEF = 7;
    localparam int DATA_BITS_DEF = 8;
    localparam logic RW_READ = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_LATCH_ADDR,
        ST_READ_LOAD,
        ST_READ_SHIFT,
        ST_WRITE_SHIFT,
        ST_WRITE_COMMIT,
        ST_DONE
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - SCLK edge counter with clear, increment and terminal-count compare
module spi_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/spi_txn_fsm.sv
// rtl/spi_txn_fsm.sv - SPI slave transaction sequencer (address, rw bit, data phase)
// Optional sticky error flag when SPI_TXN_FSM_ERR_EN is defined.
module spi_txn_fsm
    import spi_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs_n,
    input  logic                 sclk_rise,
    input  logic [DATA_BITS-1:0] shift_q,
    output logic                 addr_we,
    output logic                 sr_load,
    output logic                 dm_we,
    output logic                 miso_en,
    output logic                 busy
`ifdef SPI_TXN_FSM_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam int CNT_W = $clog2(max2(ADDR_BITS + 1, DATA_BITS) + 1);
    localparam logic [CNT_W-1:0] ADDR_TC = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] DATA_TC = CNT_W'(DATA_BITS - 1);

    state_e state_q;
    state_e state_d;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   cnt_tc;
    logic [CNT_W-1:0] cnt_term;

    // Upper bits feed the external address latch; only the rw bit is decoded here.
    logic unused_shift;
    assign unused_shift = ^shift_q[DATA_BITS-1:1];

    assign cnt_term = (state_q == ST_GET_ADDR) ? ADDR_TC : DATA_TC;

    spi_bit_counter #(.W(CNT_W)) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .term_i (cnt_term),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        addr_we = 1'b0;
        sr_load = 1'b0;
        dm_we   = 1'b0;
        miso_en = 1'b0;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (!cs_n) begin
                    state_d = ST_GET_ADDR;
                    cnt_clr = 1'b1;
                end
            end
            ST_GET_ADDR: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    if (cnt_tc) state_d = ST_LATCH_ADDR;
                    else        cnt_inc = 1'b1;
                end
            end
            ST_LATCH_ADDR: begin
                addr_we = 1'b1;
                cnt_clr = 1'b1;
                if (cs_n)                      state_d = ST_IDLE;
                else if (shift_q[0] == RW_READ) state_d = ST_READ_LOAD;
                else                           state_d = ST_WRITE_SHIFT;
            end
            ST_READ_LOAD: begin
                sr_load = 1'b1;
                state_d = cs_n ? ST_IDLE : ST_READ_SHIFT;
            end
            ST_READ_SHIFT: begin
                miso_en = 1'b1;
                if (cs_n) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    if (cnt_tc) state_d = ST_DONE;
                    else        cnt_inc = 1'b1;
                end
            end
            ST_WRITE_SHIFT: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    if (cnt_tc) state_d = ST_WRITE_COMMIT;
                    else        cnt_inc = 1'b1;
                end
            end
            ST_WRITE_COMMIT: begin
                dm_we   = 1'b1;
                state_d = cs_n ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (cs_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef SPI_TXN_FSM_ERR_EN
    logic err_q;
    logic abort_ev;
    logic ignored_ev;

    // Deselect after DONE is normal completion, not an abort.
    assign abort_ev   = cs_n && (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign ignored_ev = sclk_rise && ((state_q == ST_LATCH_ADDR) ||
                                      (state_q == ST_READ_LOAD)  ||
                                      (state_q == ST_WRITE_COMMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && !cs_n) begin
            err_q <= 1'b0;
        end else if (abort_ev || ignored_ev) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_spi_txn_fsm.sv
// tb/tb_spi_txn_fsm.sv - self-checking bench for spi_txn_fsm with a rise-counting model
module tb_spi_txn_fsm;

    localparam int A = 7;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic       sclk_rise;
    logic [7:0] shift_q;
    logic       addr_we, sr_load, dm_we, miso_en, busy;
`ifdef SPI_TXN_FSM_ERR_EN
    logic       err;
`endif

    spi_txn_fsm #(.ADDR_BITS(A), .DATA_BITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .sclk_rise (sclk_rise),
        .shift_q   (shift_q),
        .addr_we   (addr_we),
        .sr_load   (sr_load),
        .dm_we     (dm_we),
        .miso_en   (miso_en),
        .busy      (busy)
`ifdef SPI_TXN_FSM_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts address rises (k), cycles since the address completed (c),
    // counted data rises (d) and cycles since the data phase completed (e).
    bit m_busy, m_rw, m_err;
    int k, c, d, e;

    function automatic logic [4:0] m_out();
        bit ad, dp, aw, sl, dw;
        ad = m_busy && (k == A + 1);
        aw = ad && (c == 0);
        sl = ad && m_rw && (c == 1);
        dp = ad && (m_rw ? (c >= 2) : (c >= 1)) && (d < D);
        dw = m_busy && !m_rw && (d == D) && (e == 0);
        return {aw, sl, dw, (dp && m_rw), m_busy};
    endfunction

    function automatic bit m_done();
        return m_busy && (d == D) && (m_rw || (e >= 1));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [4:0] o;
        bit fixed, dp, dn;
        if (!rst_n) begin
            m_busy = 0; m_rw = 0; m_err = 0;
            k = 0; c = 0; d = 0; e = 0;
        end else begin
            o     = m_out();
            fixed = o[4] | o[3] | o[2];
            dn    = m_done();
            dp    = m_busy && (k == A + 1) && (m_rw ? (c >= 2) : (c >= 1)) && (d < D);
            if (!m_busy) begin
                if (!cs_n) begin
                    m_busy = 1; m_err = 0;
                    k = 0; c = 0; d = 0; e = 0;
                end
            end else if (cs_n) begin
                if (!dn || (fixed && sclk_rise)) m_err = 1;
                m_busy = 0;
            end else begin
                if (fixed && sclk_rise) m_err = 1;
                if (k < A + 1) begin
                    if (sclk_rise) k++;
                end else begin
                    if (c == 0) m_rw = shift_q[0];
                    if (c < 3) c++;
                    if (d == D) e++;
                    if (dp && sclk_rise) d++;
                end
            end
        end
    end

    int n_addr, n_load, n_dm, n_miso_cyc, n_miso_rise, n_idle;

    always @(negedge clk) begin
        logic [4:0] x;
        x = m_out();
        chk("addr_we", addr_we, x[4]);
        chk("sr_load", sr_load, x[3]);
        chk("dm_we",   dm_we,   x[2]);
        chk("miso_en", miso_en, x[1]);
        chk("busy",    busy,    x[0]);
`ifdef SPI_TXN_FSM_ERR_EN
        chk("err", err, m_err);
`endif
        if (addr_we) n_addr++;
        if (sr_load) n_load++;
        if (dm_we) n_dm++;
        if (miso_en) n_miso_cyc++;
        if (miso_en && sclk_rise) n_miso_rise++;
        if (!busy) n_idle++;
    end

    task automatic clr_cnt();
        n_addr = 0; n_load = 0; n_dm = 0;
        n_miso_cyc = 0; n_miso_rise = 0; n_idle = 0;
    endtask

    task automatic cyc(input logic cs, input logic r);
        cs_n = cs;
        sclk_rise = r;
        @(posedge clk);
        #1;
    endtask

    task automatic rises(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b1);
            cyc(1'b0, 1'b0);
        end
    endtask

    // Ends in the LATCH_ADDR cycle.
    task automatic addr_phase(input logic [7:0] v);
        shift_q = v;
        cyc(1'b0, 1'b0);
        rises(A);
        cyc(1'b0, 1'b1);
    endtask

    // Full write ending in the DONE cycle.
    task automatic write_body();
        addr_phase(8'hA4);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rises(D);
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; sclk_rise = 1'b0; shift_q = 8'h00;
        clr_cnt();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {addr_we, sr_load, dm_we, miso_en}, 4'b0000);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0);

        // Write to address 0x52
        clr_cnt();
        addr_phase(8'hA4);
        chk("wr_addr_we", addr_we, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rises(D - 1);
        cyc(1'b0, 1'b1);
        chk("wr_dm_we_after_8th", dm_we, 1'b1);
        cyc(1'b0, 1'b0);
        chk("wr_dm_we_one_cycle", dm_we, 1'b0);
        chk("wr_busy_done", busy, 1'b1);
        cyc(1'b1, 1'b0);
        chk("wr_busy_end", busy, 1'b0);
        chk("wr_n_addr", n_addr, 1);
        chk("wr_n_dm", n_dm, 1);
        chk("wr_n_miso", n_miso_cyc, 0);
`ifdef SPI_TXN_FSM_ERR_EN
        chk("wr_err", err, 1'b0);
`endif

        // Read
        clr_cnt();
        addr_phase(8'hA5);
        chk("rd_addr_we", addr_we, 1'b1);
        cyc(1'b0, 1'b0);
        chk("rd_sr_load", sr_load, 1'b1);
        cyc(1'b0, 1'b0);
        chk("rd_miso_on", miso_en, 1'b1);
        rises(D);
        chk("rd_miso_off", miso_en, 1'b0);
        cyc(1'b1, 1'b0);
        chk("rd_n_load", n_load, 1);
        chk("rd_n_miso_rise", n_miso_rise, D);
        chk("rd_n_dm", n_dm, 0);

        // Abort after 5th data rise
        clr_cnt();
        addr_phase(8'hA4);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rises(5);
        cyc(1'b1, 1'b0);
        chk("ab_busy", busy, 1'b0);
`ifdef SPI_TXN_FSM_ERR_EN
        chk("ab_err", err, 1'b1);
`endif
        cyc(1'b1, 1'b0);
        chk("ab_n_dm", n_dm, 0);

        // Deselect together with the 8th data rise
        clr_cnt();
        addr_phase(8'hA4);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rises(D - 1);
        cyc(1'b1, 1'b1);
        chk("sim_busy", busy, 1'b0);
        chk("sim_dm_we", dm_we, 1'b0);
        cyc(1'b1, 1'b0);
        chk("sim_n_dm", n_dm, 0);

        // Rise during LATCH_ADDR must not count
        clr_cnt();
        addr_phase(8'hA4);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        rises(D);
`ifdef SPI_TXN_FSM_ERR_EN
        chk("ign_err", err, 1'b1);
`endif
        cyc(1'b1, 1'b0);
        chk("ign_n_dm", n_dm, 1);

        // Back-to-back writes
        clr_cnt();
        write_body();
        n_idle = 0;
        cyc(1'b1, 1'b0);
        write_body();
        chk("b2b_idle_cycles", n_idle, 1);
        cyc(1'b1, 1'b0);
        chk("b2b_n_dm", n_dm, 2);
        chk("b2b_n_addr", n_addr, 2);

        // Asynchronous reset mid read shift
        addr_phase(8'hA5);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rises(3);
        chk("rs_miso_before", miso_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_busy", busy, 1'b0);
        chk("rs_outputs", {addr_we, sr_load, dm_we, miso_en}, 4'b0000);
        cs_n = 1'b1;
        sclk_rise = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0);
        chk("rs_idle_after", busy, 1'b0);
        clr_cnt();
        write_body();
        cyc(1'b1, 1'b0);
        chk("rs_write_after", n_dm, 1);

        repeat (2) cyc(1'b1, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
